// File: rtl/wave_display_pkg.sv
// Shared constants for the sample-RAM display path: RAM geometry, trace window
// defaults and FSM state encodings.
package wave_display_pkg;

  localparam int ADDR_W   = 9;
  localparam int SAMPLE_W = 8;
  localparam int WIN_WIDTH = 512;

  localparam int          X_START_DEFAULT  = 256;
  localparam int          Y_HEIGHT_DEFAULT = 512;
  localparam logic [23:0] FG_RGB_DEFAULT   = 24'hFFFFFF;
  localparam logic [23:0] BG_RGB_DEFAULT   = 24'h000000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DRAW = 1'b1;

  // Screen rows grow downward, so invert to draw larger samples higher up.
  function automatic logic [SAMPLE_W-1:0] row_level(input logic [SAMPLE_W-1:0] y_half);
    return ~y_half;
  endfunction

endpackage

// File: rtl/wave_display_trace_hit.sv
// Lights a row when it lies between the previous and current sample, giving a
// connected trace; equal samples light exactly one row.
module trace_hit
  import wave_display_pkg::*;
(
  input  logic [SAMPLE_W-1:0] prev,
  input  logic [SAMPLE_W-1:0] cur,
  input  logic [SAMPLE_W-1:0] row,
  output logic                lit
);

  logic [SAMPLE_W-1:0] lo;
  logic [SAMPLE_W-1:0] hi;

  always_comb begin
    lo  = (prev < cur) ? prev : cur;
    hi  = (prev < cur) ? cur  : prev;
    lit = (row >= lo) && (row <= hi);
  end

endmodule

// File: rtl/wave_display.sv
// Two-stage pixel pipeline that reads the released half of the sample RAM in
// step with the VGA scan and draws the waveform as a connected line.
module wave_display
  import wave_display_pkg::*;
#(
  parameter int          X_START  = X_START_DEFAULT,
  parameter int          Y_HEIGHT = Y_HEIGHT_DEFAULT,
  parameter logic [23:0] FG_RGB   = FG_RGB_DEFAULT,
  parameter logic [23:0] BG_RGB   = BG_RGB_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         x,
  input  logic [9:0]          y,
  input  logic                valid,
  input  logic                read_index,
  input  logic [SAMPLE_W-1:0] read_value,
  output logic [ADDR_W-1:0]   read_address,
  output logic                valid_pixel,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b,
  output logic                wave_display_idle
);

  logic [0:0] state_reg, state_next;
  logic       locked_index_reg, locked_index_next;

  logic [10:0] x_rel;
  logic        in_rows;
  logic        in_win;

  logic [ADDR_W-1:0]   read_address_reg;
  logic                in_win_d_reg;
  logic                x_odd_d_reg;
  logic                first_col_d_reg;
  logic [SAMPLE_W-1:0] y_half_d_reg;

  logic [SAMPLE_W-1:0] prev_reg;
  logic [SAMPLE_W-1:0] prev_sel;
  logic                lit;
  logic                valid_pixel_reg;
  logic [23:0]         rgb_reg;

  assign x_rel   = x - 11'(X_START);
  assign in_rows = 32'(y) < Y_HEIGHT;
  assign in_win  = valid && in_rows && (x_rel < 11'(WIN_WIDTH));

  // The RAM half is frozen for the whole window so capture cannot swap under us.
  always_comb begin
    state_next        = state_reg;
    locked_index_next = locked_index_reg;
    case (state_reg)
      ST_IDLE: begin
        if (valid && in_rows) begin
          state_next        = ST_DRAW;
          locked_index_next = read_index;
        end
      end
      ST_DRAW: begin
        if (valid && !in_rows) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      locked_index_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      locked_index_reg <= locked_index_next;
    end
  end

  // Stage 1: address the sample (two columns per sample) and delay coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_address_reg <= '0;
      in_win_d_reg     <= 1'b0;
      x_odd_d_reg      <= 1'b0;
      first_col_d_reg  <= 1'b0;
      y_half_d_reg     <= '0;
    end else begin
      read_address_reg <= {locked_index_next, x_rel[8:1]};
      in_win_d_reg     <= in_win;
      x_odd_d_reg      <= x_rel[0];
      first_col_d_reg  <= in_win && (x_rel == 11'd0);
      y_half_d_reg     <= y[8:1];
    end
  end

  // On the window's first column, connect the sample to itself rather than to
  // whatever ended the previous row.
  assign prev_sel = first_col_d_reg ? read_value : prev_reg;

  trace_hit u_trace_hit (
    .prev (prev_sel),
    .cur  (read_value),
    .row  (row_level(y_half_d_reg)),
    .lit  (lit)
  );

  // Stage 2: colour the pixel and advance prev on a sample's last column.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg        <= '0;
      valid_pixel_reg <= 1'b0;
      rgb_reg         <= '0;
    end else begin
      valid_pixel_reg <= in_win_d_reg;
      if (in_win_d_reg) begin
        rgb_reg <= lit ? FG_RGB : BG_RGB;
      end else begin
        rgb_reg <= '0;
      end
      if (in_win_d_reg && (x_odd_d_reg || first_col_d_reg)) begin
        prev_reg <= read_value;
      end
    end
  end

  assign read_address      = read_address_reg;
  assign valid_pixel       = valid_pixel_reg;
  assign r                 = rgb_reg[23:16];
  assign g                 = rgb_reg[15:8];
  assign b                 = rgb_reg[7:0];
  assign wave_display_idle = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_wave_display.sv
// Directed bench for wave_display with a combinational sample-RAM model.
module tb_wave_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;
  logic        wave_display_idle;

  logic [7:0] ram [512];
  int n_checks = 0;
  int n_fail   = 0;
  int lit_count;

  always #5 clk = ~clk;

  assign read_value = ram[read_address];

  wave_display dut (
    .clk               (clk),
    .reset             (reset),
    .x                 (x),
    .y                 (y),
    .valid             (valid),
    .read_index        (read_index),
    .read_value        (read_value),
    .read_address      (read_address),
    .valid_pixel       (valid_pixel),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .wave_display_idle (wave_display_idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int xi, input int yi, input logic vi);
    x     = 11'(xi);
    y     = 10'(yi);
    valid = vi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] row;
    logic       exp_lit;

    for (int i = 0; i < 512; i++) ram[i] = 8'h80;
    reset = 1'b1; x = '0; y = '0; valid = 1'b0; read_index = 1'b0;

    repeat (4) drive(0, 0, 1'b0);
    $display("txn reset held 4 cycles");
    check("rst_idle", 32'(wave_display_idle), 32'd1);
    check("rst_valid_pixel", 32'(valid_pixel), 32'd0);
    check("rst_rgb", 32'({r, g, b}), 32'h0);
    check("rst_addr", 32'(read_address), 32'h0);
    reset = 1'b0;
    drive(0, 0, 1'b0);
    check("post_rst_idle", 32'(wave_display_idle), 32'd1);

    read_index = 1'b1;
    drive(256, 0, 1'b1);
    $display("txn x=256 y=0 read_index=1");
    check("addr_x256", 32'(read_address), 32'h100);
    check("idle_drawing", 32'(wave_display_idle), 32'd0);
    drive(258, 0, 1'b1);
    $display("txn x=258 y=0");
    check("addr_x258", 32'(read_address), 32'h101);
    read_index = 1'b0;
    drive(260, 0, 1'b1);
    $display("txn x=260 y=0 read_index toggled to 0");
    check("addr_locked", 32'(read_address), 32'h102);

    // Flat trace at 0x80: only y=254,255 (inverted half-row 0x80) are lit.
    lit_count = 0;
    for (int yi = 0; yi < 512; yi++) begin
      drive(300, yi, 1'b1);
      if (yi == 254) check("latency_1cyc", 32'(valid_pixel), 32'd0);
      drive(0, 0, 1'b0);
      row = 8'(255 - (yi / 2));
      exp_lit = (row == 8'h80);
      check("flat_valid", 32'(valid_pixel), 32'd1);
      check("flat_rgb", 32'({r, g, b}), exp_lit ? 32'hFFFFFF : 32'h0);
      if ({r, g, b} == 24'hFFFFFF) lit_count++;
    end
    $display("txn flat scan x=300 lit=%0d", lit_count);
    check("flat_lit_rows", 32'(lit_count), 32'd2);

    // Rising edge 0x10 -> 0x40 fills rows 0x10..0x40: 49 levels * 2 lines.
    ram[256 + 50] = 8'h10;
    ram[256 + 51] = 8'h40;
    lit_count = 0;
    for (int yi = 0; yi < 512; yi++) begin
      drive(357, yi, 1'b1);
      drive(358, yi, 1'b1);
      drive(0, 0, 1'b0);
      row = 8'(255 - (yi / 2));
      exp_lit = (row >= 8'h10) && (row <= 8'h40);
      check("ramp_rgb", 32'({r, g, b}), exp_lit ? 32'hFFFFFF : 32'h0);
      if ({r, g, b} == 24'hFFFFFF) lit_count++;
    end
    $display("txn ramp scan x=357/358 lit=%0d", lit_count);
    check("ramp_lit_rows", 32'(lit_count), 32'd98);

    drive(255, 10, 1'b1);
    drive(0, 0, 1'b0);
    $display("txn x=255 y=10");
    check("x255_valid", 32'(valid_pixel), 32'd0);
    check("x255_rgb", 32'({r, g, b}), 32'h0);
    drive(768, 10, 1'b1);
    drive(0, 0, 1'b0);
    $display("txn x=768 y=10");
    check("x768_valid", 32'(valid_pixel), 32'd0);
    check("x768_rgb", 32'({r, g, b}), 32'h0);
    drive(767, 10, 1'b1);
    drive(0, 0, 1'b0);
    $display("txn x=767 y=10");
    check("x767_valid", 32'(valid_pixel), 32'd1);

    // First column must not connect to the stale 0x10 left in prev.
    ram[256] = 8'h20;
    drive(357, 0, 1'b1);
    drive(0, 0, 1'b0);
    drive(256, 462, 1'b1);
    drive(0, 0, 1'b0);
    $display("txn first column x=256 y=462");
    check("firstcol_unlit", 32'({r, g, b}), 32'h0);
    drive(256, 446, 1'b1);
    drive(0, 0, 1'b0);
    $display("txn first column x=256 y=446");
    check("firstcol_lit", 32'({r, g, b}), 32'hFFFFFF);

    check("idle_before_512", 32'(wave_display_idle), 32'd0);
    drive(300, 512, 1'b1);
    $display("txn x=300 y=512");
    check("idle_after_512", 32'(wave_display_idle), 32'd1);
    drive(0, 0, 1'b0);
    check("y512_valid", 32'(valid_pixel), 32'd0);

    // Load prev with 0x30, then reset mid-draw and verify prev restarts at 0.
    ram[72] = 8'h30;
    ram[74] = 8'h05;
    drive(400, 0, 1'b1);
    $display("txn x=400 y=0 read_index=0");
    check("addr_lower_half", 32'(read_address), 32'h048);
    drive(401, 0, 1'b1);
    drive(400, 0, 1'b1);
    reset = 1'b1;
    drive(400, 10, 1'b1);
    $display("txn reset during draw at x=400");
    check("midrst_idle", 32'(wave_display_idle), 32'd1);
    check("midrst_valid", 32'(valid_pixel), 32'd0);
    check("midrst_rgb", 32'({r, g, b}), 32'h0);
    check("midrst_addr", 32'(read_address), 32'h0);
    reset = 1'b0;
    drive(404, 504, 1'b1);
    check("resume_addr", 32'(read_address), 32'h04A);
    drive(0, 0, 1'b0);
    $display("txn after reset x=404 y=504");
    check("prev0_low_lit", 32'({r, g, b}), 32'hFFFFFF);
    drive(404, 446, 1'b1);
    drive(0, 0, 1'b0);
    $display("txn after reset x=404 y=446");
    check("prev0_high_unlit", 32'({r, g, b}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
